// File: rtl/fetch_ifid_stage.sv
// Instruction fetch front end: PC, imem req/gnt/rvalid handshake,
// one-entry skid buffer and IF/ID register with redirect flush.
module fetch_ifid_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [24:0] id_imm_bits,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] req_pc;
    logic        skid_valid;
    logic [31:0] skid_inst;
    logic [31:0] skid_pc;
    logic        fire;
    logic        resp;
    logic        consume;
    logic        id_free;
    logic [31:0] redir_pc;

    // Requests stall while the skid holds an instruction.
    assign imem_req    = (state == REQ) && !skid_valid;
    assign imem_addr   = pc;
    assign fire        = imem_req && imem_gnt;
    assign resp        = (state == WAIT) && imem_rvalid;
    assign consume     = id_valid && id_ready;
    assign id_free     = !id_valid || id_ready;
    assign redir_pc    = redirect_pc & ~32'h3;
    assign id_imm_bits = id_inst[31:7];
    assign id_pc_plus4 = id_pc + 32'd4;

    // Fetch FSM next state; a redirect turns any in-flight request stale.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                if (fire) state_nxt = redirect_valid ? DROP : WAIT;
            end
            WAIT: begin
                if (imem_rvalid)         state_nxt = REQ;
                else if (redirect_valid) state_nxt = DROP;
            end
            DROP: begin
                if (imem_rvalid) state_nxt = REQ;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // PC update: redirect wins over sequential increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc     <= RESET_PC;
            req_pc <= RESET_PC;
        end else begin
            if (fire) req_pc <= pc;
            if (redirect_valid) pc <= redir_pc;
            else if (fire)      pc <= pc + 32'd4;
        end
    end

    // IF/ID register and skid; skid always drains before new data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_valid   <= 1'b0;
            id_inst    <= NOP_INST;
            id_pc      <= 32'h0;
            skid_valid <= 1'b0;
            skid_inst  <= 32'h0;
            skid_pc    <= 32'h0;
        end else if (redirect_valid) begin
            id_valid   <= 1'b0;
            id_inst    <= NOP_INST;
            skid_valid <= 1'b0;
        end else if (consume && skid_valid) begin
            id_valid   <= 1'b1;
            id_inst    <= skid_inst;
            id_pc      <= skid_pc;
            skid_valid <= resp;
            skid_inst  <= imem_rdata;
            skid_pc    <= req_pc;
        end else if (resp && id_free) begin
            id_valid <= 1'b1;
            id_inst  <= imem_rdata;
            id_pc    <= req_pc;
        end else if (resp) begin
            skid_valid <= 1'b1;
            skid_inst  <= imem_rdata;
            skid_pc    <= req_pc;
        end else if (consume) begin
            id_valid <= 1'b0;
            id_inst  <= NOP_INST;
        end
    end

endmodule
